// File: rtl/cdc_fifo_pkg.sv
// Constants shared by the CDC FIFO and its read-side packer, plus the packed word/keep pair.
package cdc_fifo_pkg;

  localparam int FIFO_DATA_W       = 8;
  localparam int PACK_BYTES        = 4;
  localparam int FIFO_READ_LATENCY = 2;

  typedef struct packed {
    logic [FIFO_DATA_W*PACK_BYTES-1:0] data;
    logic [PACK_BYTES-1:0]             keep;
  } packed_word_t;

endpackage

// File: rtl/fifo_pop_tracker.sv
// Issues FIFO pops and tracks them through the read-data latency; byte_land marks the cycle a popped
// byte is on read_data_in. The inflight output exists only when PACKER_TIMEOUT_EN is defined.
module fifo_pop_tracker
  import cdc_fifo_pkg::*;
#(
  parameter int BYTES_PER_WORD = PACK_BYTES,
  parameter int READ_LATENCY   = FIFO_READ_LATENCY
) (
  input  logic                                  read_clk,
  input  logic                                  read_rst,
  input  logic                                  empty_in,
  input  logic [$clog2(BYTES_PER_WORD+1)-1:0]   asm_count,
  output logic                                  read_enable_out,
  output logic                                  byte_land
`ifdef PACKER_TIMEOUT_EN
  ,
  output logic [$clog2(READ_LATENCY+1)-1:0]     inflight
`endif
);

  localparam int IW = $clog2(READ_LATENCY + 1);

  logic [READ_LATENCY-1:0] pipe_reg;
  logic [IW-1:0]           inflight_cnt;
  logic                    pop;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + IW'(pipe_reg[i]);
    end
  end

  // pipe_reg[0] is last cycle's pop, which keeps pops off consecutive cycles
  // so the stale empty flag can never cause an over-read.
  assign pop = !read_rst && !empty_in && !pipe_reg[0]
               && ((int'(asm_count) + int'(inflight_cnt)) < BYTES_PER_WORD);

  generate
    if (READ_LATENCY == 1) begin : g_pipe_one
      always_ff @(posedge read_clk) begin
        if (read_rst) pipe_reg <= '0;
        else          pipe_reg <= pop;
      end
    end else begin : g_pipe_many
      always_ff @(posedge read_clk) begin
        if (read_rst) pipe_reg <= '0;
        else          pipe_reg <= {pipe_reg[READ_LATENCY-2:0], pop};
      end
    end
  endgenerate

  assign read_enable_out = pop;
  assign byte_land       = pipe_reg[READ_LATENCY-1];
`ifdef PACKER_TIMEOUT_EN
  assign inflight        = inflight_cnt;
`endif

endmodule

// File: rtl/fifo_read_packer.sv
// Pops bytes from the CDC FIFO read port and packs BYTES_PER_WORD of them into a valid/ready word.
// Define PACKER_TIMEOUT_EN to flush partial words after TIMEOUT_CYCLES idle cycles.
module fifo_read_packer
  import cdc_fifo_pkg::*;
#(
  parameter int DATA_W         = FIFO_DATA_W,
  parameter int BYTES_PER_WORD = PACK_BYTES,
  parameter int READ_LATENCY   = FIFO_READ_LATENCY,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             read_clk,
  input  logic                             read_rst,
  input  logic                             empty_in,
  input  logic [DATA_W-1:0]                read_data_in,
  output logic                             read_enable_out,
  output logic [DATA_W*BYTES_PER_WORD-1:0] m_data,
  output logic [BYTES_PER_WORD-1:0]        m_keep,
  output logic                             m_valid,
  input  logic                             m_ready
);

  localparam int CW = $clog2(BYTES_PER_WORD + 1);
  localparam int WW = DATA_W * BYTES_PER_WORD;

  if (BYTES_PER_WORD < 2 || READ_LATENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fifo_read_packer: invalid parameter set");
  end

  logic [DATA_W-1:0]         lane_reg  [BYTES_PER_WORD];
  logic [DATA_W-1:0]         lane_next [BYTES_PER_WORD];
  logic [CW-1:0]             asm_count_reg, asm_count_next;
  logic [BYTES_PER_WORD-1:0] keep_next;
  logic [WW-1:0]             word_next;
  logic [WW-1:0]             m_data_reg;
  logic [BYTES_PER_WORD-1:0] m_keep_reg;
  logic                      m_valid_reg;
  logic                      byte_land, slot_free, transfer_full, timeout_flush, load;
`ifdef PACKER_TIMEOUT_EN
  logic [$clog2(READ_LATENCY+1)-1:0] inflight;
`endif

  fifo_pop_tracker #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .READ_LATENCY   (READ_LATENCY)
  ) u_tracker (
    .read_clk        (read_clk),
    .read_rst        (read_rst),
    .empty_in        (empty_in),
    .asm_count       (asm_count_reg),
    .read_enable_out (read_enable_out),
    .byte_land       (byte_land)
`ifdef PACKER_TIMEOUT_EN
    ,
    .inflight        (inflight)
`endif
  );

  assign asm_count_next = asm_count_reg + CW'(byte_land);
  assign slot_free      = !m_valid_reg || m_ready;
  // A landing byte joins this cycle's transfer only when it completes the word.
  assign transfer_full  = (int'(asm_count_next) == BYTES_PER_WORD) && slot_free;
  assign load           = transfer_full || timeout_flush;

  // keep_next doubles as the partial-flush mask: a full word marks every lane.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign lane_next[gi] = (byte_land && asm_count_reg == CW'(gi)) ? read_data_in : lane_reg[gi];
      assign keep_next[gi] = CW'(gi) < asm_count_next;
      assign word_next[gi*DATA_W +: DATA_W] = keep_next[gi] ? lane_next[gi] : '0;

      always_ff @(posedge read_clk) begin
        if (read_rst) lane_reg[gi] <= '0;
        else          lane_reg[gi] <= lane_next[gi];
      end
    end
  endgenerate

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_reg;
  logic          partial_idle;

  assign partial_idle  = (asm_count_reg != '0) && (int'(asm_count_reg) < BYTES_PER_WORD)
                         && (inflight == '0) && !read_enable_out;
  assign timeout_flush = partial_idle && (idle_cnt_reg == TW'(TIMEOUT_CYCLES)) && slot_free;

  // Saturates at the threshold so a blocked flush fires as soon as the slot frees.
  always_ff @(posedge read_clk) begin
    if (read_rst || !partial_idle || timeout_flush) idle_cnt_reg <= '0;
    else if (idle_cnt_reg != TW'(TIMEOUT_CYCLES))    idle_cnt_reg <= idle_cnt_reg + TW'(1);
  end
`else
  assign timeout_flush = 1'b0;
`endif

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      asm_count_reg <= '0;
      m_data_reg    <= '0;
      m_keep_reg    <= '0;
      m_valid_reg   <= 1'b0;
    end else begin
      asm_count_reg <= load ? '0 : asm_count_next;
      if (load) begin
        m_data_reg  <= word_next;
        m_keep_reg  <= keep_next;
        m_valid_reg <= 1'b1;
      end else if (m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign m_data  = m_data_reg;
  assign m_keep  = m_keep_reg;
  assign m_valid = m_valid_reg;

endmodule
